// File: rtl/output_router_if.sv
// Result stream, route control and readback bus of the output router.
// The master side belongs to the PE array / host, the slave side to the router.
interface output_router_if #(
    parameter int SRAM_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 8
);
    logic                       i_reg_clear;
    logic                       i_start;
    logic [1:0]                 i_p_mode;
    logic [ADDR_WIDTH-1:0]      i_start_addr;
    logic [ADDR_WIDTH-1:0]      i_route_size;
    logic [DATA_WIDTH-1:0]      i_data;
    logic                       i_valid;
    logic                       o_ready;
    logic                       o_done;
    logic [ADDR_WIDTH-1:0]      o_word_count;
    logic                       i_sram_read_en;
    logic [ADDR_WIDTH-1:0]      i_read_addr;
    logic [SRAM_DATA_WIDTH-1:0] o_data_out;
    logic                       o_data_out_valid;

    modport master (
        output i_reg_clear, i_start, i_p_mode, i_start_addr, i_route_size,
               i_data, i_valid, i_sram_read_en, i_read_addr,
        input  o_ready, o_done, o_word_count, o_data_out, o_data_out_valid
    );

    modport slave (
        input  i_reg_clear, i_start, i_p_mode, i_start_addr, i_route_size,
               i_data, i_valid, i_sram_read_en, i_read_addr,
        output o_ready, o_done, o_word_count, o_data_out, o_data_out_valid
    );
endinterface

// File: rtl/output_router.sv
// Packs a serial stream of 8/4/2-bit PE results little-endian into 64-bit words
// and writes them to a local output SRAM with an independent readback port.
module output_router #(
    parameter int SRAM_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 8
) (
    input  logic            i_clk,
    input  logic            i_nrst,
    output_router_if.slave  bus
);
    localparam int SW = SRAM_DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DONE} state_t;

    state_t          state_reg, state_next;
    logic [1:0]      mode_reg;
    logic [AW-1:0]   base_reg, size_reg, cnt_reg, widx_reg, word_count_reg;
    logic [4:0]      lane_reg;
    logic [SW-1:0]   pack_reg, wr_data_reg;
    logic [AW-1:0]   wr_addr_reg;
    logic            wr_pend_reg;
    logic [SW-1:0]   rd_data_reg;
    logic            rd_valid_reg;
    logic [SW-1:0]   mem [0:(1<<AW)-1];

    logic            accept, start_ok, last_elem, word_end;
    logic [4:0]      lane_last;
    logic [5:0]      shamt;
    logic [SW-1:0]   elem_ext, pack_merged;

    assign accept   = (state_reg == ACTIVE) && bus.i_valid;
    assign start_ok = bus.i_start && ((state_reg == IDLE) || (state_reg == DONE));

    // Lane geometry for the latched precision; unused input bits never reach the word.
    always_comb begin
        lane_last = 5'd7;
        shamt     = {lane_reg[2:0], 3'b000};
        elem_ext  = {{(SW-8){1'b0}}, bus.i_data[7:0]};
        case (mode_reg)
            2'd1: begin
                lane_last = 5'd15;
                shamt     = {lane_reg[3:0], 2'b00};
                elem_ext  = {{(SW-4){1'b0}}, bus.i_data[3:0]};
            end
            2'd2: begin
                lane_last = 5'd31;
                shamt     = {lane_reg, 1'b0};
                elem_ext  = {{(SW-2){1'b0}}, bus.i_data[1:0]};
            end
            default: ;
        endcase
    end

    assign pack_merged = pack_reg | (elem_ext << shamt);
    assign last_elem   = (cnt_reg + 1'b1) == size_reg;
    assign word_end    = (lane_reg == lane_last) || last_elem;

    always_comb begin
        state_next = state_reg;
        if (bus.i_reg_clear) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE, DONE: if (bus.i_start)
                    state_next = (bus.i_route_size == '0) ? DONE : ACTIVE;
                ACTIVE:     if (accept && last_elem) state_next = FLUSH;
                // The final word is always pending here and commits at this edge.
                FLUSH:      state_next = DONE;
                default:    state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            mode_reg       <= '0;
            base_reg       <= '0;
            size_reg       <= '0;
            cnt_reg        <= '0;
            widx_reg       <= '0;
            lane_reg       <= '0;
            pack_reg       <= '0;
            wr_data_reg    <= '0;
            wr_addr_reg    <= '0;
            wr_pend_reg    <= 1'b0;
            word_count_reg <= '0;
        end else if (bus.i_reg_clear) begin
            cnt_reg        <= '0;
            widx_reg       <= '0;
            lane_reg       <= '0;
            pack_reg       <= '0;
            wr_pend_reg    <= 1'b0;
            word_count_reg <= '0;
        end else begin
            wr_pend_reg <= 1'b0;
            if (wr_pend_reg) word_count_reg <= word_count_reg + 1'b1;
            if (start_ok) begin
                mode_reg       <= (bus.i_p_mode == 2'd3) ? 2'd0 : bus.i_p_mode;
                base_reg       <= bus.i_start_addr;
                size_reg       <= bus.i_route_size;
                cnt_reg        <= '0;
                widx_reg       <= '0;
                lane_reg       <= '0;
                pack_reg       <= '0;
                word_count_reg <= '0;
            end else if (accept) begin
                cnt_reg <= cnt_reg + 1'b1;
                if (word_end) begin
                    wr_data_reg <= pack_merged;
                    wr_addr_reg <= base_reg + widx_reg;
                    wr_pend_reg <= 1'b1;
                    widx_reg    <= widx_reg + 1'b1;
                    pack_reg    <= '0;
                    lane_reg    <= '0;
                end else begin
                    pack_reg <= pack_merged;
                    lane_reg <= lane_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_pend_reg && !bus.i_reg_clear) mem[wr_addr_reg] <= wr_data_reg;
    end

    // Read-before-write: a read colliding with a commit sees the old word.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= bus.i_sram_read_en;
            if (bus.i_sram_read_en) rd_data_reg <= mem[bus.i_read_addr];
        end
    end

    assign bus.o_ready          = (state_reg == ACTIVE);
    assign bus.o_done           = (state_reg == DONE);
    assign bus.o_word_count     = word_count_reg;
    assign bus.o_data_out       = rd_data_reg;
    assign bus.o_data_out_valid = rd_valid_reg;
endmodule

// File: tb/tb_output_router.sv
// Self-checking bench for output_router: table-driven routes, clear/zero-size
// sequences and randomized gapped routes against an arithmetic packing model.
module tb_output_router;
    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    output_router_if bus();
    output_router dut (.i_clk(clk), .i_nrst(nrst), .bus(bus));

    int total = 0;
    int bad   = 0;
    logic [63:0] ref_mem [0:255];
    logic [7:0]  rlist [5] = '{8'h10, 8'h11, 8'h20, 8'hFF, 8'h00};

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  addr;
        int          size;
        int          kind;
        bit          gapped;
        logic [63:0] w0;
        logic [63:0] w1;
        int          cnt;
    } vec_t;
    vec_t tab [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic read_check(input logic [7:0] a, input logic [63:0] exp, input string nm);
        bus.i_sram_read_en = 1'b1;
        bus.i_read_addr    = a;
        step();
        bus.i_sram_read_en = 1'b0;
        chk({nm, "_vld"}, 64'(bus.o_data_out_valid), 64'd1);
        chk(nm, bus.o_data_out, exp);
        $display("read  addr=%h data=%h", a, bus.o_data_out);
    endtask

    // Runs one route and checks handshake timing, word count and every packed word.
    task automatic run_route(input logic [1:0] mode, input logic [7:0] addr, input int size,
                             input int kind, input bit gapped, input string nm);
        int e, w, nwords, idx, cyc, rd_pend;
        bit v;
        logic [7:0]  rd_a;
        logic [7:0]  elems [256];
        logic [63:0] words [33];
        e = (mode == 2'd1) ? 16 : (mode == 2'd2) ? 32 : 8;
        w = 64 / e;
        for (int i = 0; i < 256; i++)
            elems[i] = (kind == 0) ? 8'(i + 1) : (kind == 1) ? 8'(8'hA1 + 8'h11 * i) :
                       (kind == 2) ? 8'(i % 4) : 8'($urandom);
        nwords = (size + e - 1) / e;
        for (int i = 0; i < 33; i++) words[i] = '0;
        for (int i = 0; i < size; i++)
            words[i / e] = words[i / e] | (64'(int'(elems[i]) & ((1 << w) - 1)) << ((i % e) * w));

        bus.i_start = 1'b1; bus.i_p_mode = mode; bus.i_start_addr = addr;
        bus.i_route_size = 8'(size);
        step();
        bus.i_start = 1'b0;
        bus.i_p_mode = 2'($urandom); bus.i_start_addr = 8'($urandom);
        bus.i_route_size = 8'($urandom);
        chk({nm, "_done_low"}, 64'(bus.o_done), 64'd0);
        idx = 0; cyc = 0; rd_pend = 0; rd_a = '0;
        while (idx < size && cyc < 2000) begin
            chk({nm, "_ready"}, 64'(bus.o_ready), 64'd1);
            if (rd_pend != 0) begin
                chk({nm, "_crd_vld"}, 64'(bus.o_data_out_valid), 64'd1);
                chk({nm, "_crd"}, bus.o_data_out, ref_mem[rd_a]);
            end
            v = gapped ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.i_valid = v;
            bus.i_data  = v ? elems[idx] : 8'($urandom);
            bus.i_start = gapped && ($urandom_range(0, 9) == 0);
            if (gapped) begin
                rd_a = rlist[$urandom_range(0, 4)];
                bus.i_sram_read_en = 1'b1; bus.i_read_addr = rd_a; rd_pend = 1;
            end
            step();
            cyc++;
            if (v) idx++;
        end
        if (idx < size) chk({nm, "_budget"}, 64'(idx), 64'(size));
        bus.i_valid = 1'b0; bus.i_start = 1'b0; bus.i_sram_read_en = 1'b0;
        if (rd_pend != 0) chk({nm, "_crd"}, bus.o_data_out, ref_mem[rd_a]);
        chk({nm, "_ready_drop"}, 64'(bus.o_ready), 64'd0);
        chk({nm, "_done_k1"}, 64'(bus.o_done), 64'd0);
        step();
        chk({nm, "_done_k2"}, 64'(bus.o_done), 64'd1);
        chk({nm, "_wcount"}, 64'(bus.o_word_count), 64'(nwords));
        for (int k = 0; k < nwords; k++) begin
            ref_mem[8'(addr + 8'(k))] = words[k];
            read_check(8'(addr + 8'(k)), words[k], {nm, "_word"});
        end
        $display("route %s mode=%0d addr=%h size=%0d words=%0d cycles=%0d",
                 nm, mode, addr, size, nwords, cyc);
    endtask

    initial begin
        tab[0] = '{2'd0, 8'h10, 16, 0, 1'b0, 64'h0807060504030201, 64'h100F0E0D0C0B0A09, 2};
        tab[1] = '{2'd1, 8'h20, 5,  1, 1'b0, 64'h0000000000054321, 64'h0, 1};
        tab[2] = '{2'd2, 8'hFF, 40, 2, 1'b0, 64'hE4E4E4E4E4E4E4E4, 64'h000000000000E4E4, 2};
        tab[3] = '{2'd0, 8'h30, 16, 0, 1'b1, 64'h0807060504030201, 64'h100F0E0D0C0B0A09, 2};

        nrst = 1'b0;
        bus.i_reg_clear = 0; bus.i_start = 0; bus.i_p_mode = 0; bus.i_start_addr = 0;
        bus.i_route_size = 0; bus.i_data = 0; bus.i_valid = 0;
        bus.i_sram_read_en = 0; bus.i_read_addr = 0;
        #12;
        chk("rst_ready", 64'(bus.o_ready), 64'd0);
        chk("rst_done", 64'(bus.o_done), 64'd0);
        chk("rst_wcount", 64'(bus.o_word_count), 64'd0);
        chk("rst_dout", bus.o_data_out, 64'd0);
        chk("rst_dvld", 64'(bus.o_data_out_valid), 64'd0);
        nrst = 1'b1;
        step();

        for (int t = 0; t < 4; t++) begin
            run_route(tab[t].mode, tab[t].addr, tab[t].size, tab[t].kind, tab[t].gapped, $sformatf("tab%0d", t));
            chk($sformatf("tab%0d_cnt", t), 64'(bus.o_word_count), 64'(tab[t].cnt));
            read_check(tab[t].addr, tab[t].w0, $sformatf("tab%0d_w0", t));
            if (tab[t].cnt > 1) read_check(8'(tab[t].addr + 8'd1), tab[t].w1, $sformatf("tab%0d_w1", t));
        end

        // Zero-size route from IDLE: done the next cycle, no writes.
        bus.i_reg_clear = 1'b1; step(); bus.i_reg_clear = 1'b0;
        chk("clr_done", 64'(bus.o_done), 64'd0);
        bus.i_start = 1'b1; bus.i_p_mode = 2'd0; bus.i_start_addr = 8'h10; bus.i_route_size = 8'd0;
        step();
        bus.i_start = 1'b0;
        chk("zero_done", 64'(bus.o_done), 64'd1);
        chk("zero_ready", 64'(bus.o_ready), 64'd0);
        chk("zero_wcount", 64'(bus.o_word_count), 64'd0);
        step();
        read_check(8'h10, ref_mem[8'h10], "zero_keep");
        $display("seq zero-size done");

        // Clear after five elements, with start and valid also asserted.
        bus.i_start = 1'b1; bus.i_p_mode = 2'd0; bus.i_start_addr = 8'h20; bus.i_route_size = 8'd16;
        step();
        bus.i_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.i_valid = 1'b1; bus.i_data = 8'(8'h55 + i); step();
        end
        bus.i_reg_clear = 1'b1; bus.i_start = 1'b1; step();
        bus.i_reg_clear = 1'b0; bus.i_start = 1'b0; bus.i_valid = 1'b0;
        chk("clr_ready", 64'(bus.o_ready), 64'd0);
        chk("clr_wcount", 64'(bus.o_word_count), 64'd0);
        chk("clr_done2", 64'(bus.o_done), 64'd0);
        step();
        chk("clr_idle", 64'(bus.o_ready), 64'd0);
        read_check(8'h20, ref_mem[8'h20], "clr_keep");
        $display("seq clear mid-route done");
        run_route(2'd0, 8'h20, 16, 0, 1'b0, "after_clr");
        chk("after_clr_w0", ref_mem[8'h20], 64'h0807060504030201);

        for (int r = 0; r < 6; r++)
            run_route(2'($urandom_range(0, 3)), 8'(8'h40 + $urandom_range(0, 32)),
                      $urandom_range(1, 255), 3, 1'b1, $sformatf("rnd%0d", r));

        step();
        chk("dout_hold_vld", 64'(bus.o_data_out_valid), 64'd0);
        chk("dout_hold", bus.o_data_out, ref_mem[dut_last_read()]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Address of the most recent readback, tracked from the stimulus side.
    logic [7:0] last_rd_addr;
    always @(posedge clk) if (bus.i_sram_read_en) last_rd_addr <= bus.i_read_addr;
    function automatic logic [7:0] dut_last_read();
        return last_rd_addr;
    endfunction
endmodule
